// File: rtl/banked_mem_pkg.sv
// Shared constants for the four-bank, word-interleaved memory responder.
// Field positions describe how a 16-bit byte address splits into index/bank/byte.
package banked_mem_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DATA_W    = 16;
    localparam int BANK_LSB  = 1;
    localparam int BANK_MSB  = 2;
    localparam int IDX_LSB   = 3;
    localparam int IDX_MSB   = 15;
    localparam int RD_LAT    = 2;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/mem_bank.sv
// One word-wide memory bank: storage, write port, registered read port
// and the occupancy counter that keeps the bank busy after each access.
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int BANK_BUSY = 4,
    parameter int BANK_AW   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic [BANK_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_en,
    input  logic [BANK_AW-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);

    logic [DATA_W-1:0] r_mem [2**BANK_AW];
    logic [DATA_W-1:0] r_rdata_p2;
    logic [CNT_W-1:0]  r_cnt;

    // Array is deliberately not reset; a write accepted before reset stays committed.
    always_ff @(posedge clk) begin
        if (i_acc && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_rd_en) begin
            r_rdata_p2 <= r_mem[i_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_acc) begin
            r_cnt <= CNT_W'(BANK_BUSY - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_rdata = r_rdata_p2;
    assign o_busy  = (r_cnt != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Memory-side responder for cache line fills and write-backs: request decode,
// bank steering and the two-stage read return pipeline over four mem_bank instances.
module banked_mem_responder
    import banked_mem_pkg::*;
#(
    parameter int BANK_BUSY = 4,
    parameter int BANK_AW   = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          Addr,
    input  logic [DATA_W-1:0]    DataIn,
    input  logic                 Rd,
    input  logic                 Wr,
    output logic [DATA_W-1:0]    DataOut,
    output logic                 DataOut_valid,
    output logic                 Stall,
    output logic [NUM_BANKS-1:0] Busy,
    output logic                 err
);

    logic                 w_req;
    logic                 w_bad;
    logic                 w_acc;
    logic [1:0]           w_bank;
    logic [BANK_AW-1:0]   w_idx;
    logic [NUM_BANKS-1:0] w_busy;
    logic [DATA_W-1:0]    w_rdata [NUM_BANKS];

    logic                 r_vld_p1;
    logic [1:0]           r_bank_p1;
    logic [BANK_AW-1:0]   r_idx_p1;
    logic                 r_vld_p2;
    logic [1:0]           r_bank_p2;

    assign w_bank = Addr[BANK_MSB:BANK_LSB];
    assign w_idx  = Addr[IDX_LSB +: BANK_AW];

    // A conflicting or odd-address request is dropped outright and never stalls.
    assign w_req = Rd | Wr;
    assign w_bad = (Rd & Wr) | (w_req & Addr[0]);
    assign w_acc = w_req & ~w_bad & ~w_busy[w_bank];
    assign err   = w_bad;
    assign Stall = w_req & ~w_bad & w_busy[w_bank];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .BANK_BUSY (BANK_BUSY),
            .BANK_AW   (BANK_AW)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_acc     (w_acc && (w_bank == 2'(b))),
            .i_we      (Wr),
            .i_addr    (w_idx),
            .i_wdata   (DataIn),
            .i_rd_en   (r_vld_p1 && (r_bank_p1 == 2'(b))),
            .i_rd_addr (r_idx_p1),
            .o_rdata   (w_rdata[b]),
            .o_busy    (w_busy[b])
        );
    end

    // Stage 1: accepted read captured; stage 2: array word registered inside the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_acc & Rd;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        r_bank_p1 <= w_bank;
        r_idx_p1  <= w_idx;
        r_bank_p2 <= r_bank_p1;
    end

    // Output: data is forced to zero whenever no read completes.
    assign DataOut       = r_vld_p2 ? w_rdata[r_bank_p2] : '0;
    assign DataOut_valid = r_vld_p2;
    assign Busy          = w_busy;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder: a driver predicts accept/stall/busy
// and queues expected read returns; a monitor pops and compares on DataOut_valid.
module tb_banked_mem_responder;
    import banked_mem_pkg::*;

    localparam int BB = 4;

    typedef struct {
        logic [15:0] data;
        bit          known;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        DataOut_valid;
    logic        Stall;
    logic [3:0]  Busy;
    logic        err;

    banked_mem_responder #(
        .BANK_BUSY (BB),
        .BANK_AW   (13)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Addr          (Addr),
        .DataIn        (DataIn),
        .Rd            (Rd),
        .Wr            (Wr),
        .DataOut       (DataOut),
        .DataOut_valid (DataOut_valid),
        .Stall         (Stall),
        .Busy          (Busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          free_at [4];
    exp_t        q [$];
    logic [15:0] mem_m [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_busy();
        logic [3:0] bz;
        for (int i = 0; i < 4; i++) bz[i] = (cyc < free_at[i]);
        return bz;
    endfunction

    // Present one request, hold it while stalled, and update the reference model on acceptance.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, output int stalls);
        bit   req, bad, exp_stall, done;
        int   b, key;
        exp_t e;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        stalls = 0;
        done = 0;
        for (int k = 0; k < 32 && !done; k++) begin
            @(negedge clk);
            req = rd | wr;
            bad = (rd & wr) | (req & a[0]);
            b   = int'(a[2:1]);
            key = int'(a[15:1]);
            exp_stall = req && !bad && (cyc < free_at[b]);
            chk("err", 32'(err), 32'(bad));
            chk("stall", 32'(Stall), 32'(exp_stall));
            chk("busy", 32'(Busy), 32'(model_busy()));
            if (!exp_stall) begin
                if (req && !bad) begin
                    free_at[b] = cyc + BB;
                    if (wr) begin
                        mem_m[key] = d;
                    end else begin
                        e.known = mem_m.exists(key);
                        e.data  = e.known ? mem_m[key] : 16'h0000;
                        e.cyc   = cyc + RD_LAT;
                        q.push_back(e);
                    end
                end
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        Rd = 1'b0; Wr = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: addr %h still stalled after %0d cycles", a, stalls);
        end
    endtask

    task automatic idle(input int n);
        Rd = 1'b0; Wr = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", 32'(Busy), 32'(model_busy()));
            chk("idle_stall", 32'(Stall), 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every cycle out of reset, match read returns against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_read: expected data %h at cycle %0d did not arrive", q[0].data, q[0].cyc);
                    void'(q.pop_front());
                end
                if (DataOut_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 32'(DataOut_valid), 32'h0);
                    end else begin
                        e = q.pop_front();
                        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.known) chk("rd_data", 32'(DataOut), 32'(e.data));
                    end
                end else begin
                    chk("idle_dataout", 32'(DataOut), 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [15:0] a, d;
        int op;
        logic [15:0] wb_addr [4] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236};
        logic [15:0] wb_data [4] = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};

        for (int i = 0; i < 4; i++) free_at[i] = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_valid", 32'(DataOut_valid), 32'h0);
        chk("rst_dataout", 32'(DataOut), 32'h0);
        chk("rst_stall", 32'(Stall), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Line write-back then line fill
        for (int i = 0; i < 4; i++) do_req(0, 1, wb_addr[i], wb_data[i], s);
        idle(BB + 1);
        for (int i = 0; i < 4; i++) do_req(1, 0, wb_addr[i], 16'h0, s);
        idle(BB + 2);

        // Bank conflict on bank 0
        do_req(0, 1, 16'h0040, 16'h4040, s);
        do_req(0, 1, 16'h0048, 16'h4848, s);
        idle(BB + 1);
        do_req(1, 0, 16'h0040, 16'h0, s);
        do_req(1, 0, 16'h0048, 16'h0, s);
        chk("conflict_stalls", 32'(s), 32'(BB - 1));
        idle(BB + 2);

        // Illegal requests leave state untouched
        do_req(1, 1, 16'h0040, 16'hDEAD, s);
        do_req(1, 0, 16'h0041, 16'h0, s);
        do_req(0, 1, 16'h0041, 16'hBAD0, s);
        chk("illegal_busy", 32'(Busy), 32'h0);
        do_req(1, 0, 16'h0040, 16'h0, s);
        idle(BB + 2);

        // Write then read of the same word
        do_req(0, 1, 16'h2000, 16'hBEEF, s);
        do_req(1, 0, 16'h2000, 16'h0, s);
        chk("wr_rd_stalls", 32'(s), 32'(BB - 1));
        idle(BB + 2);

        // Reset during a read: the write before reset persists, the read never returns
        do_req(0, 1, 16'h3010, 16'h5A5A, s);
        do_req(1, 0, 16'h0048, 16'h0, s);
        rst = 1'b1;
        #1;
        q.delete();
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        chk("midrst_busy", 32'(Busy), 32'h0);
        chk("midrst_valid", 32'(DataOut_valid), 32'h0);
        chk("midrst_dataout", 32'(DataOut), 32'h0);
        chk("midrst_stall", 32'(Stall), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_valid", 32'(DataOut_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        do_req(1, 0, 16'h3010, 16'h0, s);
        idle(BB + 2);

        // Randomized traffic over a pre-initialised window
        for (int idx = 0; idx < 8; idx++)
            for (int b = 0; b < 4; b++)
                do_req(0, 1, 16'((16'h100 + idx) << 3) | 16'(b << 1), 16'($urandom), s);
        idle(BB + 1);
        for (int it = 0; it < 300; it++) begin
            a  = 16'((16'h100 + $urandom_range(0, 7)) << 3) | 16'($urandom_range(0, 3) << 1);
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            d  = 16'($urandom);
            op = $urandom_range(0, 9);
            if (op <= 3)      do_req(1, 0, a, d, s);
            else if (op <= 6) do_req(0, 1, a, d, s);
            else if (op == 7) do_req(1, 1, a, d, s);
            else              idle(1);
        end
        idle(BB + 4);
        chk("drain", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
